fcvt_sched: RTL and testbench
=============================

FCVT_SCHED -- requirements
Module: fcvt_sched

Interface
REQ-001 Parameter LAT, default 2, SHALL be the fixed pipeline latency in cycles of fcvt_s_w and fcvt_w_s.
REQ-002 Parameter DEPTH, default 4, SHALL be the per-requester result FIFO depth and credit limit.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1  SHALL indicate that a conversion request is presented by requester 0 / 1.
REQ-006 req0_ready / req1_ready  output  1  SHALL indicate that the request is accepted this cycle; a transfer occurs on valid&&ready.
REQ-007 req0_op / req1_op  input  1  SHALL select the operation: 0 = fcvt.s.w (int32 to float32), 1 = fcvt.w.s (float32 to int32, round-to-nearest-even).
REQ-008 req0_x / req1_x  input  32  SHALL carry the operand bits.
REQ-009 resp0_valid / resp1_valid  output  1  SHALL indicate that a result is available at the head of that requester's FIFO.
REQ-010 resp0_ready / resp1_ready  input  1  SHALL pop the head result when asserted together with valid.
REQ-011 resp0_y / resp1_y  output  32  SHALL carry the head result bits.

Function
REQ-012 At most one request SHALL be issued per cycle to the shared fcvt_s_w/fcvt_w_s pair; the unit selected by op receives the operand, and the other unit receives 0.
REQ-013 Arbitration SHALL be round-robin with a one-bit last-grant pointer.
REQ-014 When both requesters are eligible, the grant SHALL go to the requester not recorded in the pointer.
REQ-015 When only one requester is eligible, the grant SHALL go to it.
REQ-016 The pointer SHALL update only on an accepted transfer.
REQ-017 Requester i SHALL be eligible only if reqi_valid=1 and inflight_i + fifo_count_i < DEPTH.
REQ-018 reqi_ready SHALL equal grant_i, and it SHALL NOT depend combinationally on respi_ready.
REQ-019 Each issue SHALL push {requester id, op} into a LAT-stage tag shift register.
REQ-020 The result SHALL be written into the tagged requester's FIFO at the edge LAT cycles after the accept edge.
REQ-021 respi_valid SHALL assert in the cycle following that write edge; there is no bypass.
REQ-022 inflight_i SHALL increment on an accept and decrement on a FIFO write; a simultaneous accept and write SHALL leave it unchanged.
REQ-023 fifo_count_i SHALL increment on a write and decrement on a pop.
REQ-024 When a write and a pop occur in the same cycle on a full FIFO, the count SHALL stay at DEPTH, and REQ-017 SHALL make overflow impossible.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH.
REQ-026 Results to each requester SHALL be delivered in acceptance order; there is no ordering between requesters.
REQ-027 With resp ready held at 1, the sustained throughput SHALL be 1 op/cycle total; one requester alone SHALL also achieve 1 op/cycle once DEPTH > LAT+1.
REQ-028 Stalling one requester's response side SHALL NOT block the other requester.

Reset
REQ-029 While rstn=0, req*_ready and resp*_valid SHALL be 0.
REQ-030 While rstn=0, resp*_y SHALL be 0.
REQ-031 While rstn=0, the tag valid bits SHALL be cleared, the counts and FIFO pointers SHALL be 0, and the pointer SHALL be set to 1 so that requester 0 wins the first tie.
REQ-032 Operations in flight at reset assertion SHALL be discarded, and no response for them SHALL appear after rstn rises.
REQ-033 The first accept SHALL be possible in the first cycle after rstn deasserts.

Structure
REQ-034 Package fpu_pkg SHALL hold the op encoding typedef (FCVT_S_W=0, FCVT_W_S=1), the tag struct {id, op, valid} and the default LAT constant.
REQ-035 The per-requester result buffer SHALL be one sub-module fcvt_resp_fifo (parameter DEPTH, width 32), instantiated twice.
REQ-036 The arbiter and tag pipeline SHALL stay in the top level.

Verification
REQ-037 Requester 0 issues op=0, x=0x00000001, with resp0_ready=1 -> resp0_y=0x3F800000 appears LAT+1 cycles after accept.
REQ-038 Requester 1 issues op=0, x=0xFFFFFFFF, then op=1, x=0x40490FDB, back to back -> resp1_y=0xBF800000 and then 0x00000003, in order.
REQ-039 Both requesters hold valid=1 for 8 cycles with resp ready=1 -> grants alternate 0,1,0,1,... and each requester receives 4 results.
REQ-040 resp0_ready=0 with req0 valid continuously -> exactly DEPTH accepts, then req0_ready stays 0 while requester 1 keeps 1 op/cycle; raising resp0_ready drains 4 results in order.
REQ-041 Write and pop on the same cycle while the FIFO is full -> fifo_count stays DEPTH with no loss or duplication.
REQ-042 rstn pulsed low with 2 ops in flight -> all outputs are 0 during reset, and no stale resp_valid appears afterwards.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the conversion scheduler.
//   FCVT_LAT   : default pipeline latency of the conversion units
//   fcvt_op_e  : operation select (int32->float32 / float32->int32)
//   fcvt_tag_t : per-issue tag carried alongside the unit pipelines
//   f_i2f      : int32 -> float32, round-to-nearest-even
//   f_f2i      : float32 -> int32, round-to-nearest-even, saturating
package fpu_pkg;

    localparam int FCVT_LAT = 2;

    typedef enum logic {
        FCVT_S_W = 1'b0,
        FCVT_W_S = 1'b1
    } fcvt_op_e;

    typedef struct packed {
        logic     id;
        fcvt_op_e op;
        logic     valid;
    } fcvt_tag_t;

    function automatic logic [31:0] f_i2f(input logic [31:0] x);
        logic [31:0] mag;
        logic [31:0] norm;
        logic [30:0] exman;
        logic        rnd;
        int          p;
        mag = x[31] ? (~x + 32'd1) : x;
        p   = 0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) p = i;
        end
        // Leading one moved to bit 31; bits [7:0] are the guard/sticky tail.
        norm  = mag << (31 - p);
        rnd   = norm[7] & ((|norm[6:0]) | norm[8]);
        // Rounding carry out of the mantissa bumps the exponent for free.
        exman = {8'(127 + p), norm[30:8]} + 31'(rnd);
        // norm[31] is clear only for a zero input.
        return norm[31] ? {x[31], exman} : 32'd0;
    endfunction

    function automatic logic [31:0] f_f2i(input logic [31:0] x);
        logic [7:0]  e;
        logic [23:0] sig;
        logic [55:0] wide;
        logic [31:0] mag;
        logic [31:0] res;
        logic        rnd;
        e    = x[30:23];
        sig  = {|e, x[22:0]};
        // Integer part lands in [55:32], fraction in [31:0].
        wide = {sig, 32'd0} >> (8'd150 - e);
        rnd  = wide[31] & ((|wide[30:0]) | wide[32]);
        mag  = {8'd0, wide[55:32]} + 32'(rnd);
        if (e >= 8'd150) mag = {8'd0, sig} << (e - 8'd150);
        res  = x[31] ? (~mag + 32'd1) : mag;
        if (e == 8'hFF && x[22:0] != 23'd0) res = 32'h7FFF_FFFF;
        else if (e >= 8'd158)               res = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return res;
    endfunction

endpackage

// File: rtl/fcvt_resp_fifo.sv
// Per-requester result FIFO.
//   clk, rstn             : clock, async active-low reset
//   wr_en_i / wr_data_i   : push a result
//   rd_en_i               : consumer ready; pops when a result is present
//   rd_valid_o / rd_data_o: head result (data forced to 0 when empty)
//   count_o               : current occupancy, used for credit accounting
module fcvt_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         wr_en_i,
    input  logic [W-1:0]                 wr_data_i,
    input  logic                         rd_en_i,
    output logic                         rd_valid_o,
    output logic [W-1:0]                 rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign rd_valid_o = (cnt_q != '0);
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = cnt_q;
    assign pop        = rd_en_i && rd_valid_o;

    // Writes never target a full FIFO unless the same edge pops: the
    // scheduler's credit check bounds in-flight plus stored results.
    always_comb begin
        wr_ptr_d = wr_en_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop     ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(wr_en_i) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/fcvt_sched.sv
// Two-requester scheduler for a shared fcvt.s.w / fcvt.w.s unit pair.
//   clk, rstn                  : clock, async active-low reset
//   reqN_valid/ready/op/x      : request channel per requester (op 0 = s.w, 1 = w.s)
//   respN_valid/ready/y        : result channel per requester, in acceptance order
// Round-robin arbiter with credit-based flow control, LAT-deep tag pipeline
// steering each result into the issuing requester's FIFO.
module fcvt_sched
    import fpu_pkg::*;
#(
    parameter int LAT   = FCVT_LAT,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_op,
    input  logic [31:0] req0_x,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_op,
    input  logic [31:0] req1_x,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [31:0] resp0_y,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp1_y
);
    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);

    logic [1:0]          req_valid, elig, grant, wr_en, resp_valid, resp_ready;
    logic [1:0][CW-1:0]  inflight_q, inflight_d, fifo_cnt;
    logic [1:0][31:0]    resp_y;
    logic                last_q, last_d;
    logic                issue;
    fcvt_op_e            iss_op;
    logic [31:0]         iss_x, sw_in, ws_in, wr_data;
    fcvt_tag_t           tag_q [LAT];
    fcvt_tag_t           out_tag;
    logic [31:0]         sw_q  [LAT];
    logic [31:0]         ws_q  [LAT];

    assign req_valid  = {req1_valid, req0_valid};
    assign resp_ready = {resp1_ready, resp0_ready};

    // Credit: a requester may only issue while its in-flight plus stored
    // results leave room in its FIFO, so a write never overflows.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            elig[i] = req_valid[i] && (({1'b0, inflight_q[i]} + {1'b0, fifo_cnt[i]}) < DEPTH_W);
        end
        grant = elig;
        if (elig == 2'b11) grant = last_q ? 2'b01 : 2'b10;
    end

    // Grant is combinational from counters held at 0 in reset, so the
    // outputs are masked explicitly while rstn is low.
    assign req0_ready = grant[0] & rstn;
    assign req1_ready = grant[1] & rstn;

    always_comb begin
        issue  = |grant;
        iss_op = fcvt_op_e'(grant[1] ? req1_op : req0_op);
        iss_x  = grant[1] ? req1_x : req0_x;
        sw_in  = (issue && iss_op == FCVT_S_W) ? iss_x : '0;
        ws_in  = (issue && iss_op == FCVT_W_S) ? iss_x : '0;
        last_d = issue ? grant[1] : last_q;
    end

    // Unit result pipelines; no reset needed, validity travels in tag_q.
    always_ff @(posedge clk) begin
        sw_q[0] <= f_i2f(sw_in);
        ws_q[0] <= f_f2i(ws_in);
        for (int k = 1; k < LAT; k++) begin
            sw_q[k] <= sw_q[k-1];
            ws_q[k] <= ws_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0] <= '{id: grant[1], op: iss_op, valid: issue};
            for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    always_comb begin
        out_tag  = tag_q[LAT-1];
        wr_data  = (out_tag.op == FCVT_W_S) ? ws_q[LAT-1] : sw_q[LAT-1];
        wr_en[0] = out_tag.valid && !out_tag.id;
        wr_en[1] = out_tag.valid &&  out_tag.id;
        for (int i = 0; i < 2; i++) begin
            inflight_d[i] = inflight_q[i] + CW'(grant[i]) - CW'(wr_en[i]);
        end
    end

    // last_q resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_q <= '0;
            last_q     <= 1'b1;
        end else begin
            inflight_q <= inflight_d;
            last_q     <= last_d;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_fifo
        fcvt_resp_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
            .clk        (clk),
            .rstn       (rstn),
            .wr_en_i    (wr_en[i]),
            .wr_data_i  (wr_data),
            .rd_en_i    (resp_ready[i]),
            .rd_valid_o (resp_valid[i]),
            .rd_data_o  (resp_y[i]),
            .count_o    (fifo_cnt[i])
        );
    end

    assign resp0_valid = resp_valid[0];
    assign resp1_valid = resp_valid[1];
    assign resp0_y     = resp_y[0];
    assign resp1_y     = resp_y[1];

endmodule

// File: tb/tb_fcvt_sched.sv
`timescale 1ns/1ps
module tb_fcvt_sched;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic        req0_valid = 1'b0, req0_op = 1'b0, req1_valid = 1'b0, req1_op = 1'b0;
    logic [31:0] req0_x = '0, req1_x = '0;
    logic        req0_ready, req1_ready;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b1, resp1_ready = 1'b1;
    logic [31:0] resp0_y, resp1_y;

    fcvt_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_x(req0_x),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_x(req1_x),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_y(resp0_y),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_y(resp1_y)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] y; int acc; } exp_t;
    exp_t sb [2][$];
    int   checks = 0, errors = 0, cyc = 0;
    int   last_g = 1;
    int   acc_cnt [2] = '{0, 0};
    bit   lat_exact = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_i2f(input logic [31:0] x);
        logic [63:0] b;
        logic [30:0] em;
        logic        rnd;
        if (x == 32'd0) return 32'd0;
        b   = $realtobits($itor($signed(x)));       // exact in double
        rnd = b[28] && ((b[27:0] != 28'd0) || b[29]);
        em  = {8'(b[62:52] - 11'd896), b[51:29]} + 31'(rnd);
        return {b[63], em};
    endfunction

    function automatic logic [31:0] ref_f2i(input logic [31:0] x);
        int  e;
        real v, fl, r;
        e = int'(x[30:23]);
        if (e == 255 && x[22:0] != 23'd0) return 32'h7FFF_FFFF;
        if (e == 255) return x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        v = (e == 0) ? 0.0 : 1.0 + $itor(x[22:0]) / 8388608.0;
        for (int k = 0; k < e - 127; k++) v = v * 2.0;
        for (int k = 0; k < 127 - e; k++) v = v / 2.0;
        if (x[31]) v = -v;
        fl = $floor(v);
        r  = fl;
        if ((v - fl > 0.5) || ((v - fl == 0.5) && ($floor(fl / 2.0) * 2.0 != fl))) r = fl + 1.0;
        if (r > 2147483647.0)  return 32'h7FFF_FFFF;
        if (r < -2147483648.0) return 32'h8000_0000;
        return 32'(longint'(r));
    endfunction

    function automatic logic [31:0] ref_conv(input logic op, input logic [31:0] x);
        return op ? ref_f2i(x) : ref_i2f(x);
    endfunction

    function automatic logic [31:0] rnd_x(input logic op);
        logic [31:0] v;
        int unsigned k;
        k = $urandom_range(0, 11);
        v = $urandom;
        if (op) begin
            case (k)
                0: v = 32'h3F00_0000;     // 0.5  -> 0
                1: v = 32'h3FC0_0000;     // 1.5  -> 2
                2: v = 32'hC020_0000;     // -2.5 -> -2
                3: v = 32'h4F00_0000;     // 2^31 saturates
                4: v = 32'hCF00_0000;     // -2^31 exact
                5: v = 32'h7FC0_0000;     // NaN
                6: v = 32'hFF80_0000;     // -inf
                default: v = {v[31], 8'($urandom_range(100, 165)), v[22:0]};
            endcase
        end else begin
            case (k)
                0: v = 32'd0;
                1: v = 32'h8000_0000;
                2: v = 32'h7FFF_FFFF;
                3: v = 32'h0100_0001;
                default: ;
            endcase
        end
        return v;
    endfunction

    // ---------------- issue side: arbitration model + scoreboard push ----------------
    always @(negedge clk) begin : iss
        bit         e0, e1;
        logic [1:0] eg;
        #1;
        if (!rstn) begin
            chk("rst_req_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        end else begin
            e0 = req0_valid && (sb[0].size() < DEPTH);
            e1 = req1_valid && (sb[1].size() < DEPTH);
            if (e0 && e1) eg = (last_g == 1) ? 2'b01 : 2'b10;
            else          eg = {e1, e0};
            chk("grant", {30'd0, req1_ready, req0_ready}, {30'd0, eg});
            if (req0_valid && req0_ready) begin
                sb[0].push_back('{ref_conv(req0_op, req0_x), cyc});
                last_g = 0;
                acc_cnt[0]++;
            end
            if (req1_valid && req1_ready) begin
                sb[1].push_back('{ref_conv(req1_op, req1_x), cyc});
                last_g = 1;
                acc_cnt[1]++;
            end
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge clk) begin : mon
        logic [1:0]  v, r;
        logic [31:0] y [2];
        exp_t        e;
        #2;
        v = {resp1_valid, resp0_valid};
        r = {resp1_ready, resp0_ready};
        y[0] = resp0_y;
        y[1] = resp1_y;
        for (int i = 0; i < 2; i++) begin
            if (!rstn) begin
                chk($sformatf("rst_resp%0d_valid", i), 32'(v[i]), 32'd0);
                chk($sformatf("rst_resp%0d_y", i), y[i], 32'd0);
            end else if (v[i] && r[i]) begin
                if (sb[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp%0d_spurious: got y=%h, expected no response (cycle %0d)", i, y[i], cyc);
                end else begin
                    e = sb[i].pop_front();
                    chk($sformatf("resp%0d_y", i), y[i], e.y);
                    if (lat_exact) chk($sformatf("resp%0d_lat", i), 32'(cyc - e.acc), 32'(LAT + 1));
                    else begin
                        checks++;
                        if (cyc - e.acc < LAT + 1) begin
                            errors++;
                            $display("FAIL resp%0d_lat: got %0d cycles, expected >= %0d", i, cyc - e.acc, LAT + 1);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0/0", sb[0].size(), sb[1].size());
        end
        repeat (2) tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int a0, a1;
        #1 rstn = 1'b0;
        repeat (3) tick();

        // First accept right after reset release: requester 0, int 1 -> 1.0f.
        rstn = 1'b1;
        req0_valid = 1'b1; req0_op = 1'b0; req0_x = 32'h0000_0001;
        tick();
        req0_valid = 1'b0;
        drain();

        // Requester 1 back to back: -1 -> -1.0f, then pi -> 3.
        req1_valid = 1'b1; req1_op = 1'b0; req1_x = 32'hFFFF_FFFF;
        tick();
        req1_op = 1'b1; req1_x = 32'h4049_0FDB;
        tick();
        req1_valid = 1'b0;
        drain();

        // Both requesters busy for 8 cycles: alternate grants, 4 each.
        a0 = acc_cnt[0]; a1 = acc_cnt[1];
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req0_op = 1'($urandom_range(0, 1)); req0_x = rnd_x(req0_op);
            req1_op = 1'($urandom_range(0, 1)); req1_x = rnd_x(req1_op);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_acc0", 32'(acc_cnt[0] - a0), 32'd4);
        chk("rr_acc1", 32'(acc_cnt[1] - a1), 32'd4);
        drain();

        // Stall requester 0's responses; requester 1 must keep streaming.
        lat_exact = 1'b0;
        resp0_ready = 1'b0;
        a0 = acc_cnt[0]; a1 = acc_cnt[1];
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            req0_op = 1'($urandom_range(0, 1)); req0_x = rnd_x(req0_op);
            req1_op = 1'($urandom_range(0, 1)); req1_x = rnd_x(req1_op);
            tick();
        end
        req1_valid = 1'b0;
        chk("stall_acc0", 32'(acc_cnt[0] - a0), 32'(DEPTH));
        chk("stall_acc1", 32'(acc_cnt[1] - a1), 32'(20 - DEPTH));
        // FIFO 0 full; keep requesting while popping so writes and pops overlap.
        repeat (LAT + 2) tick();
        resp0_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req0_op = 1'($urandom_range(0, 1)); req0_x = rnd_x(req0_op);
            tick();
        end
        req0_valid = 1'b0;
        drain();

        // Random traffic with random back-pressure.
        for (int c = 0; c < 400; c++) begin
            req0_valid  = ($urandom_range(0, 9) < 7);
            req1_valid  = ($urandom_range(0, 9) < 7);
            req0_op = 1'($urandom_range(0, 1)); req0_x = rnd_x(req0_op);
            req1_op = 1'($urandom_range(0, 1)); req1_x = rnd_x(req1_op);
            resp0_ready = ($urandom_range(0, 9) < 6);
            resp1_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        drain();
        lat_exact = 1'b1;

        // Reset with operations in flight: they must vanish.
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 1'b0; req0_x = 32'd7;
        req1_op = 1'b1; req1_x = 32'h4120_0000;
        repeat (2) tick();
        rstn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        sb[0].delete();
        sb[1].delete();
        last_g = 1;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (10) tick();

        req0_valid = 1'b1; req0_op = 1'b1; req0_x = 32'h4049_0FDB;
        tick();
        req0_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
